// File: rtl/reversible_pkg.sv
// Shared definitions for the reversible serial adder: FSM state encoding and
// the default operand width.
package reversible_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reversible_full_adder.sv
// Reversible full adder: the A and B inputs are carried through unchanged as
// garbage outputs so the caller can confirm the gate did not corrupt them.
module reversible_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_a,
  output logic o_b,
  output logic o_sum,
  output logic o_cout
);

  logic w_p;

  // Peres-style cascade: propagate term first, then sum and carry from it.
  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_c;
  assign o_cout = (i_a & i_b) ^ (w_p & i_c);
  assign o_a    = i_a;
  assign o_b    = i_b;

endmodule

// File: rtl/reversible_serial_adder.sv
// Bit-serial adder built around one reversible full adder: operands are
// processed LSB first, one bit per clock, and the result is held until the next start.
module reversible_serial_adder
  import reversible_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             garbage_err,
  output state_e           dbg_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_gerr;
  logic [IDX_W-1:0] r_idx;

  logic w_bit_a;
  logic w_bit_b;
  logic w_fa_a;
  logic w_fa_b;
  logic w_fa_sum;
  logic w_fa_cout;
  logic w_last;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];
  assign w_last  = (r_idx == IDX_W'(WIDTH - 1));

  reversible_full_adder u_fa (
    .i_a    (w_bit_a),
    .i_b    (w_bit_b),
    .i_c    (r_carry),
    .o_a    (w_fa_a),
    .o_b    (w_fa_b),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_gerr  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_gerr  <= 1'b0;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0.
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_cout;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_fa_cout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
          if ((w_fa_a != w_bit_a) || (w_fa_b != w_bit_b)) r_gerr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign garbage_err = r_gerr;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_reversible_serial_adder.sv
// Bench for reversible_serial_adder: directed corner cases, mid-run start and
// reset, back-to-back operation and random vectors against an a+b+cin model.
module tb_reversible_serial_adder;
  import reversible_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         garbage_err;
  state_e       dbg_state;

  logic [W:0] exp_q[$];
  int         done_cyc[$];
  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         cyc      = 0;

  reversible_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .garbage_err (garbage_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned total;
    total = int'(x) + int'(y) + int'(c);
    return total[W:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W:0] e;
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        check("garbage_err", 32'(garbage_err), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One operation; optionally re-pulses start with other operands mid-run.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit glitch);
    int n = 0;
    @(negedge clk);
    wait_idle();
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back(ref_add(ta, tb_v, tc));
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (glitch && n == 4) begin
        a = ~ta; b = tb_v ^ 8'h5C; cin = ~tc; start = 1'b1;
      end
      if (glitch && n == 5) start = 1'b0;
      if (done) break;
    end
    check("done_latency_edges", 32'(n), 32'(W + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic reset_mid_run();
    int n = 0;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    wait_idle();
    a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
    exp_q.push_back(ref_add(8'hFF, 8'h00, 1'b0));
    while (n < 5) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    check("sum_partial", 32'(sum), 32'h0F0);
    check("busy_mid_run", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_garbage", 32'(garbage_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
  endtask

  task automatic back_to_back();
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic         bc[3];
    int accepted = 0;
    int d0;
    int guard = 0;
    logic prev_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ba[i] = W'($urandom_range(0, 255));
      bb[i] = W'($urandom_range(0, 255));
      bc[i] = 1'($urandom_range(0, 1));
    end
    d0 = done_cnt;
    @(negedge clk);
    wait_idle();
    a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
    exp_q.push_back(ref_add(ba[0], bb[0], bc[0]));
    while (guard < 100 && (done_cnt - d0) < 3) begin
      @(negedge clk);
      guard++;
      if (busy && !prev_busy) begin
        accepted++;
        if (accepted < 3) begin
          a = ba[accepted]; b = bb[accepted]; cin = bc[accepted];
          exp_q.push_back(ref_add(ba[accepted], bb[accepted], bc[accepted]));
        end else begin
          start = 1'b0;
        end
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
    if (done_cyc.size() >= 3) begin
      check("b2b_spacing_1", 32'(done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3]),
            32'(W + 2));
      check("b2b_spacing_2", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]),
            32'(W + 2));
    end else begin
      check("b2b_done_history", 32'(done_cyc.size()), 32'd3);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_garbage", 32'(garbage_err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_release", 32'(busy), 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0);

    d0 = done_cnt;
    run_op(8'h12, 8'h34, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("single_done_with_restart", 32'(done_cnt - d0), 32'd1);

    reset_mid_run();
    run_op(8'h10, 8'h20, 1'b0, 1'b0);

    back_to_back();

    for (int i = 0; i < 256; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
